// File: rtl/adc_serial_capture_if.sv
// Pin-level bundle between the serial ADC capture master and its surroundings.
//   start_p       request one conversion (single cycle)
//   sdo_p         ADC serial data, MSB first
//   cnv_p         ADC convert strobe
//   sck_p         ADC serial clock, idles low
//   data_p        last captured sample
//   data_valid_p  one-cycle strobe marking a new data_p
//   busy_p        conversion in progress
//   overrun_p     start_p seen while busy_p was high
// The capture block uses the master modport; the ADC/consumer side uses slave.
interface adc_serial_capture_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  start_p;
    logic                  sdo_p;
    logic                  cnv_p;
    logic                  sck_p;
    logic [DATA_WIDTH-1:0] data_p;
    logic                  data_valid_p;
    logic                  busy_p;
    logic                  overrun_p;

    modport master (
        input  start_p,
        input  sdo_p,
        output cnv_p,
        output sck_p,
        output data_p,
        output data_valid_p,
        output busy_p,
        output overrun_p
    );

    modport slave (
        output start_p,
        output sdo_p,
        input  cnv_p,
        input  sck_p,
        input  data_p,
        input  data_valid_p,
        input  busy_p,
        input  overrun_p
    );
endinterface

// File: rtl/adc_serial_capture.sv
// Master for a serial-readout conversion ADC. On start_p it pulses CNV, waits
// the conversion time, then generates DATA_WIDTH SCK pulses, shifting SDO in
// MSB first on each SCK rising edge. The finished word appears on data_p with
// a one-cycle data_valid_p strobe.
//   clk_p      system clock
//   reset_n_p  asynchronous active-low reset
//   bus        pin/handshake bundle (master modport); all outputs registered
module adc_serial_capture #(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned CNV_HIGH_CYCLES  = 2,
    parameter int unsigned CONV_WAIT_CYCLES = 4,
    parameter int unsigned SCK_HALF_CYCLES  = 2
) (
    input logic                  clk_p,
    input logic                  reset_n_p,
    adc_serial_capture_if.master bus
);
    localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);
    localparam logic [7:0]  CnvLast  = 8'(CNV_HIGH_CYCLES - 1);
    localparam logic [7:0]  WaitLast = 8'(CONV_WAIT_CYCLES - 1);
    localparam logic [7:0]  HalfLast = 8'(SCK_HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCnvHigh,
        StConvWait,
        StSckLow,
        StSckHigh
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  cnv_q, cnv_d;
    logic                  sck_q, sck_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        cnv_d     = cnv_q;
        sck_d     = sck_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        // busy_q is low in the data_valid_p cycle, so a start there is legal.
        overrun_d = bus.start_p & busy_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start_p) begin
                    state_d   = StCnvHigh;
                    cnv_d     = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            StCnvHigh: begin
                if (cnt_q == CnvLast) begin
                    cnt_d   = '0;
                    cnv_d   = 1'b0;
                    state_d = StConvWait;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StConvWait: begin
                if (cnt_q == WaitLast) begin
                    cnt_d   = '0;
                    state_d = StSckLow;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StSckLow: begin
                if (cnt_q == HalfLast) begin
                    // Sample on the same edge that raises SCK.
                    cnt_d     = '0;
                    sck_d     = 1'b1;
                    shift_d   = {shift_q[DATA_WIDTH-2:0], bus.sdo_p};
                    bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    state_d   = StSckHigh;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StSckHigh: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    if (bit_cnt_q == BitCntW'(DATA_WIDTH)) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        state_d = StSckLow;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            cnv_q     <= 1'b0;
            sck_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            cnv_q     <= cnv_d;
            sck_q     <= sck_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.cnv_p        = cnv_q;
    assign bus.sck_p        = sck_q;
    assign bus.data_p       = data_q;
    assign bus.data_valid_p = valid_q;
    assign bus.busy_p       = busy_q;
    assign bus.overrun_p    = overrun_q;
endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture: a default-parameter instance and a
// fast (1/1/1) instance, each fed by a behavioural ADC responder.
module tb_adc_serial_capture;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    adc_serial_capture_if #(.DATA_WIDTH(16)) bus ();
    adc_serial_capture_if #(.DATA_WIDTH(16)) bus_f ();

    adc_serial_capture #(
        .DATA_WIDTH(16), .CNV_HIGH_CYCLES(2), .CONV_WAIT_CYCLES(4), .SCK_HALF_CYCLES(2)
    ) dut (
        .clk_p(clk), .reset_n_p(reset_n), .bus(bus.master)
    );

    adc_serial_capture #(
        .DATA_WIDTH(16), .CNV_HIGH_CYCLES(1), .CONV_WAIT_CYCLES(1), .SCK_HALF_CYCLES(1)
    ) dut_f (
        .clk_p(clk), .reset_n_p(reset_n), .bus(bus_f.master)
    );

    int checks = 0;
    int failures = 0;

    // ADC responders: word latched on CNV rise, next bit presented after each SCK fall.
    logic [15:0] next_word = 16'h0000;
    logic [15:0] cur_word = 16'h0000;
    int          bit_idx = 16;
    always @(posedge bus.cnv_p or negedge bus.sck_p) begin
        if (bus.cnv_p) begin
            cur_word = next_word;
            bit_idx  = 0;
        end else begin
            bit_idx = bit_idx + 1;
        end
    end
    assign bus.sdo_p = (bit_idx < 16) ? cur_word[4'(15 - bit_idx)] : 1'b0;

    logic [15:0] next_word_f = 16'h0000;
    logic [15:0] cur_word_f = 16'h0000;
    int          bit_idx_f = 16;
    always @(posedge bus_f.cnv_p or negedge bus_f.sck_p) begin
        if (bus_f.cnv_p) begin
            cur_word_f = next_word_f;
            bit_idx_f  = 0;
        end else begin
            bit_idx_f = bit_idx_f + 1;
        end
    end
    assign bus_f.sdo_p = (bit_idx_f < 16) ? cur_word_f[4'(15 - bit_idx_f)] : 1'b0;

    // Edge counter and event monitors for the default instance.
    int   edge_cnt = 0;
    int   cnv_rises = 0;
    int   valid_cnt = 0;
    int   overrun_cnt = 0;
    int   active_cnt = 0;
    logic cnv_prev = 1'b0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(negedge clk) begin
        cnv_prev <= bus.cnv_p;
        if (bus.cnv_p && !cnv_prev) cnv_rises <= cnv_rises + 1;
        if (bus.data_valid_p) valid_cnt <= valid_cnt + 1;
        if (bus.overrun_p) overrun_cnt <= overrun_cnt + 1;
        if (bus.cnv_p || bus.sck_p || bus.data_valid_p || bus.busy_p)
            active_cnt <= active_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps until data_valid_p (bounded); clears start_p after the first edge.
    task automatic wait_valid(output int edge_at);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            bus.start_p = 1'b0;
            n++;
        end while (!bus.data_valid_p && n < 300);
        chk("valid_seen", {31'b0, bus.data_valid_p}, 32'd1);
        edge_at = edge_cnt;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, ev1, ev2, ev3, c0, v0, o0, a0;
        logic [3:0] exp_v;
        reset_n       = 1'b0;
        bus.start_p   = 1'b0;
        bus_f.start_p = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {10'b0, bus.cnv_p, bus.sck_p, bus.data_valid_p, bus.busy_p, bus.overrun_p,
             bus.data_p, 1'b0}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle: 200 cycles without start.
        a0 = active_cnt;
        repeat (200) @(posedge clk);
        #1;
        chk("idle_active_cycles", 32'(active_cnt - a0), 32'd0);

        // Single conversion, cycle-by-cycle waveform.
        next_word   = 16'hA5C3;
        o0          = overrun_cnt;
        bus.start_p = 1'b1;
        for (int k = 0; k <= 70; k++) begin
            @(posedge clk);
            #1;
            bus.start_p = 1'b0;
            exp_v[3] = (k < 2);
            exp_v[2] = (k >= 8) && (k <= 69) && (((k - 7) % 4 == 1) || ((k - 7) % 4 == 2));
            exp_v[1] = (k < 70);
            exp_v[0] = (k == 70);
            chk($sformatf("single_wave_c%0d", k),
                {28'b0, bus.cnv_p, bus.sck_p, bus.busy_p, bus.data_valid_p}, {28'b0, exp_v});
        end
        chk("single_data", {16'b0, bus.data_p}, 32'h0000A5C3);
        @(posedge clk);
        #1;
        chk("single_valid_drop", {31'b0, bus.data_valid_p}, 32'd0);
        chk("single_data_hold", {16'b0, bus.data_p}, 32'h0000A5C3);
        chk("single_no_overrun", 32'(overrun_cnt - o0), 32'd0);

        // Back-to-back conversions, start issued in each valid cycle.
        o0          = overrun_cnt;
        next_word   = 16'hFFFF;
        bus.start_p = 1'b1;
        e0          = edge_cnt;
        wait_valid(ev1);
        chk("b2b_latency0", 32'(ev1 - (e0 + 1)), 32'd70);
        chk("b2b_data0", {16'b0, bus.data_p}, 32'h0000FFFF);
        next_word   = 16'h0000;
        bus.start_p = 1'b1;
        wait_valid(ev2);
        chk("b2b_period1", 32'(ev2 - ev1), 32'd71);
        chk("b2b_data1", {16'b0, bus.data_p}, 32'h00000000);
        next_word   = 16'h8001;
        bus.start_p = 1'b1;
        wait_valid(ev3);
        chk("b2b_period2", 32'(ev3 - ev2), 32'd71);
        chk("b2b_data2", {16'b0, bus.data_p}, 32'h00008001);
        @(posedge clk);
        #1;
        chk("b2b_no_overrun", 32'(overrun_cnt - o0), 32'd0);

        // Start re-pulsed 10 cycles into a conversion.
        next_word   = 16'h3C96;
        c0          = cnv_rises;
        v0          = valid_cnt;
        o0          = overrun_cnt;
        bus.start_p = 1'b1;
        e0          = edge_cnt;
        @(posedge clk);
        #1;
        bus.start_p = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.start_p = 1'b1;
        @(posedge clk);
        #1;
        bus.start_p = 1'b0;
        chk("ovr_pulse", {31'b0, bus.overrun_p}, 32'd1);
        @(posedge clk);
        #1;
        chk("ovr_pulse_end", {31'b0, bus.overrun_p}, 32'd0);
        wait_valid(ev1);
        chk("ovr_latency", 32'(ev1 - (e0 + 1)), 32'd70);
        chk("ovr_data", {16'b0, bus.data_p}, 32'h00003C96);
        @(posedge clk);
        #1;
        chk("ovr_cnv_count", 32'(cnv_rises - c0), 32'd1);
        chk("ovr_valid_count", 32'(valid_cnt - v0), 32'd1);
        chk("ovr_overrun_count", 32'(overrun_cnt - o0), 32'd1);

        // Reset during bit 7 aborts the transfer.
        next_word   = 16'hBEEF;
        bus.start_p = 1'b1;
        @(posedge clk);
        #1;
        bus.start_p = 1'b0;
        repeat (36) @(posedge clk);
        #1;
        v0      = valid_cnt;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outputs",
            {10'b0, bus.cnv_p, bus.sck_p, bus.data_valid_p, bus.busy_p, bus.overrun_p,
             bus.data_p, 1'b0}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("rst_no_strobe", 32'(valid_cnt - v0), 32'd0);
        chk("rst_data_cleared", {16'b0, bus.data_p}, 32'd0);
        next_word   = 16'h1234;
        bus.start_p = 1'b1;
        e0          = edge_cnt;
        wait_valid(ev1);
        chk("rst_after_latency", 32'(ev1 - (e0 + 1)), 32'd70);
        chk("rst_after_data", {16'b0, bus.data_p}, 32'h00001234);

        // Fast instance: 1/1/1 timing, latency 34.
        next_word_f   = 16'h5A5A;
        bus_f.start_p = 1'b1;
        for (int k = 0; k <= 34; k++) begin
            @(posedge clk);
            #1;
            bus_f.start_p = 1'b0;
            exp_v[3] = (k < 1);
            exp_v[2] = (k >= 3) && (k <= 33) && (k % 2 == 1);
            exp_v[1] = (k < 34);
            exp_v[0] = (k == 34);
            chk($sformatf("fast_wave_c%0d", k),
                {28'b0, bus_f.cnv_p, bus_f.sck_p, bus_f.busy_p, bus_f.data_valid_p},
                {28'b0, exp_v});
        end
        chk("fast_data", {16'b0, bus_f.data_p}, 32'h00005A5A);
        chk("fast_no_overrun", {31'b0, bus_f.overrun_p}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
